// File: rtl/forthsuper_pkg.sv
// ---------------------------------------------------------------------------
// forthsuper_pkg
// Shared definitions for the forthsuper byte-memory subsystem.
//   arb_state_e : arbiter FSM states (IDLE / GRANT / LOCKED)
//   PORT_*      : requester index of each memory client on mb8_arbiter
//   idxWidth()  : bit width needed to hold an index in 0..n-1 (minimum 1)
// ---------------------------------------------------------------------------
package forthsuper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    localparam int PORT_INNER  = 0;
    localparam int PORT_OUTER  = 1;
    localparam int PORT_OUTBUF = 2;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mb8_arb_pick.sv
// ---------------------------------------------------------------------------
// mb8_arb_pick
// Combinational N-way rotating priority picker. Scans requesters starting at
// index i_start and wrapping modulo N; the first one with its request high
// and its mask bit low wins.
//   i_req   [N]  : request vector
//   i_mask  [N]  : requesters excluded from this pick
//   i_start [IW] : first index searched
//   o_gnt   [N]  : one-hot winner (zero when no eligible request)
//   o_idx   [IW] : winner index
//   o_valid      : a winner exists
// ---------------------------------------------------------------------------
module mb8_arb_pick
    import forthsuper_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = idxWidth(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_start) + k) % N;
            if (!o_valid && i_req[w_pos] && !i_mask[w_pos]) begin
                o_valid      = 1'b1;
                o_idx        = IW'(w_pos);
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mb8_arbiter.sv
// ---------------------------------------------------------------------------
// mb8_arbiter
// Byte-wide memory arbiter for N requesters (0 = inner interpreter,
// 1 = outer interpreter, 2 = output buffer) sharing one memory block with a
// registered (1-cycle) read port. Grants are combinational in the request
// cycle; a requester holding lock keeps ownership for a multi-byte burst of
// at most LOCK_MAX beats, after which it sits out one arbitration cycle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_req/i_lock/i_we   : per-requester request, burst lock, write enable
//   i_addr, i_wdata     : per-requester byte address and write byte
//   o_gnt               : one-hot grant, access issued this cycle
//   o_rvalid, o_rdata   : read return, one cycle after a granted read
//   o_mem_a/_we/_din    : memory block address, write strobe, write data
//   i_mem_dout          : memory block read data
//
// Build option
//   MB8_ARB_RR_EN : when defined, round-robin arbitration starting at the
//                   last winner + 1; otherwise fixed priority (lowest index).
// ---------------------------------------------------------------------------
module mb8_arbiter
    import forthsuper_pkg::*;
#(
    parameter int ASZ      = 17,
    parameter int N        = 3,
    parameter int LOCK_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             i_req,
    input  logic [N-1:0]             i_lock,
    input  logic [N-1:0]             i_we,
    input  logic [N-1:0][ASZ-1:0]    i_addr,
    input  logic [N-1:0][7:0]        i_wdata,
    output logic [N-1:0]             o_gnt,
    output logic [N-1:0]             o_rvalid,
    output logic [7:0]               o_rdata,
    output logic [ASZ-1:0]           o_mem_a,
    output logic                     o_mem_we,
    output logic [7:0]               o_mem_din,
    input  logic [7:0]               i_mem_dout
);

    localparam int IW = idxWidth(N);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e      r_state;
    arb_state_e      w_nextState;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_nextOwner;
    logic [CW-1:0]   r_lockCnt;
    logic [CW-1:0]   w_nextCnt;
    logic [CW-1:0]   w_cntInc;
    logic [N-1:0]    r_excl;
    logic [N-1:0]    w_nextExcl;
    logic [N-1:0]    r_rvalid;
    logic [ASZ-1:0]  r_memA;

    logic [IW-1:0]   w_start;
    logic [N-1:0]    w_pickGnt;
    logic [IW-1:0]   w_pickIdx;
    logic            w_pickValid;
    logic            w_lockHit;
    logic            w_gntValid;
    logic [IW-1:0]   w_gntIdx;

`ifdef MB8_ARB_RR_EN
    logic [IW-1:0]   r_last;
    assign w_start = (int'(r_last) == N - 1) ? '0 : r_last + IW'(1);
`else
    assign w_start = '0;
`endif

    mb8_arb_pick #(
        .N (N)
    ) u_pick (
        .i_req   (i_req),
        .i_mask  (r_excl),
        .i_start (w_start),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    // A locked owner bypasses the picker only while it is still requesting;
    // once it lets go, the others are arbitrated in that same cycle.
    assign w_lockHit  = (r_state == LOCKED) && i_req[r_owner];
    assign w_gntValid = !rst && (w_lockHit || w_pickValid);
    assign w_gntIdx   = w_lockHit ? r_owner : w_pickIdx;
    assign w_cntInc   = r_lockCnt + CW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= IW'(PORT_INNER);
            r_lockCnt <= '0;
            r_excl    <= '0;
            r_rvalid  <= '0;
            r_memA    <= '0;
`ifdef MB8_ARB_RR_EN
            r_last    <= IW'(N - 1);
`endif
        end else begin
            r_state   <= w_nextState;
            r_owner   <= w_nextOwner;
            r_lockCnt <= w_nextCnt;
            r_excl    <= w_nextExcl;
            r_rvalid  <= o_gnt & ~i_we;
            if (w_gntValid) begin
                r_memA <= i_addr[w_gntIdx];
`ifdef MB8_ARB_RR_EN
                r_last <= w_gntIdx;
`endif
            end
        end
    end

    // Next-state logic. A burst that hits LOCK_MAX with lock still high
    // masks its owner for exactly the following cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextCnt   = r_lockCnt;
        w_nextExcl  = '0;
        if (!w_gntValid) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
        end else if (w_lockHit) begin
            if (!i_lock[r_owner]) begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end else if (int'(w_cntInc) >= LOCK_MAX) begin
                w_nextState         = IDLE;
                w_nextCnt           = '0;
                w_nextExcl[r_owner] = 1'b1;
            end else begin
                w_nextState = LOCKED;
                w_nextCnt   = w_cntInc;
            end
        end else begin
            w_nextOwner = w_pickIdx;
            if (!i_lock[w_pickIdx]) begin
                w_nextState = GRANT;
                w_nextCnt   = '0;
            end else if (LOCK_MAX <= 1) begin
                w_nextState           = IDLE;
                w_nextCnt             = '0;
                w_nextExcl[w_pickIdx] = 1'b1;
            end else begin
                w_nextState = LOCKED;
                w_nextCnt   = CW'(1);
            end
        end
    end

    // Output logic. Memory address holds its last granted value when idle
    // and is forced to zero while in reset.
    always_comb begin
        o_gnt     = '0;
        o_mem_a   = r_memA;
        o_mem_we  = 1'b0;
        o_mem_din = '0;
        if (rst) begin
            o_mem_a = '0;
        end else if (w_gntValid) begin
            if (w_lockHit) begin
                o_gnt[r_owner] = 1'b1;
            end else begin
                o_gnt = w_pickGnt;
            end
            o_mem_a   = i_addr[w_gntIdx];
            o_mem_we  = i_we[w_gntIdx];
            o_mem_din = i_wdata[w_gntIdx];
        end
    end

    // A read granted just before reset must not surface during reset.
    assign o_rvalid = rst ? '0 : r_rvalid;
    assign o_rdata  = i_mem_dout;

endmodule

// File: tb/tb_mb8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mb8_arbiter
// Directed self-checking bench for mb8_arbiter with a registered byte
// memory model attached to the memory port. Expected values follow the
// fixed-priority build by default and the round-robin build when
// MB8_ARB_RR_EN is defined.
// ---------------------------------------------------------------------------
module tb_mb8_arbiter;
    import forthsuper_pkg::*;

    localparam int ASZ = 17;
    localparam int N   = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0]          lock;
    logic [N-1:0]          we;
    logic [N-1:0][ASZ-1:0] addr;
    logic [N-1:0][7:0]     wdata;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [7:0]            rdata;
    logic [ASZ-1:0]        memA;
    logic                  memWe;
    logic [7:0]            memDin;
    logic [7:0]            memDout;

    logic [7:0]            memArr [0:(1<<ASZ)-1];
    logic                  preWe;
    logic [ASZ-1:0]        preA;
    logic [7:0]            preD;

    int errors = 0;
    int checks = 0;

    logic [7:0]   burstData [4];
    logic [N-1:0] expGnt;
    logic [N-1:0] prevGnt;

    always #5 clk = ~clk;

    mb8_arbiter #(
        .ASZ      (ASZ),
        .N        (N),
        .LOCK_MAX (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req),
        .i_lock     (lock),
        .i_we       (we),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_gnt      (gnt),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_mem_a    (memA),
        .o_mem_we   (memWe),
        .o_mem_din  (memDin),
        .i_mem_dout (memDout)
    );

    // Registered memory block, with a bench-side preload port.
    always @(posedge clk) begin
        if (preWe) begin
            memArr[preA] <= preD;
        end else if (memWe) begin
            memArr[memA] <= memDin;
        end
        memDout <= memArr[memA];
    end

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [N-1:0] w);
        req  = r;
        lock = l;
        we   = w;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ASZ-1:0] a, input logic [7:0] d);
        preA  = a;
        preD  = d;
        preWe = 1'b1;
        nextCycle();
        preWe = 1'b0;
    endtask

    initial begin
        burstData[0] = 8'h11;
        burstData[1] = 8'h22;
        burstData[2] = 8'h33;
        burstData[3] = 8'h44;
        preWe = 1'b0;
        preA  = '0;
        preD  = '0;
        rst   = 1'b1;
        for (int i = 0; i < N; i++) begin
            addr[i]  = 17'h12345;
            wdata[i] = 8'hEE;
        end
        applyStimulus(3'b111, 3'b000, 3'b111);
        nextCycle();

        // Reset with every requester asking to write
        preload(17'h00010, 8'hA5);
        for (int b = 0; b < 4; b++) preload(17'h00100 + 17'(b), burstData[b]);
        @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_mem_we", memWe, 0);
        checkOutput("rst_mem_a", memA, 0);
        checkOutput("rst_mem_din", memDin, 0);
        nextCycle();

        rst = 1'b0;
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("idle_gnt", gnt, 0);
        checkOutput("idle_mem_a", memA, 0);
        nextCycle();

        // Single read from the inner interpreter
        addr[PORT_INNER] = 17'h00010;
        applyStimulus(3'b001, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("rd_gnt", gnt, 3'b001);
        checkOutput("rd_mem_a", memA, 17'h00010);
        checkOutput("rd_mem_we", memWe, 0);
        nextCycle();
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("rd_rvalid", rvalid, 3'b001);
        checkOutput("rd_rdata", rdata, 8'hA5);
        checkOutput("rd_gnt_after", gnt, 0);
        checkOutput("rd_mem_a_hold", memA, 17'h00010);
        nextCycle();

        // Fresh reset so the round-robin pointer starts from N-1
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;

        // Contention: all three reading for six cycles
        for (int i = 0; i < N; i++) addr[i] = 17'h00020;
        applyStimulus(3'b111, 3'b000, 3'b000);
        prevGnt = '0;
        for (int i = 0; i < 6; i++) begin
`ifdef MB8_ARB_RR_EN
            expGnt = 3'b001 << (i % 3);
`else
            expGnt = 3'b001;
`endif
            @(negedge clk);
            checkOutput($sformatf("cont_gnt_%0d", i), gnt, expGnt);
            if (i > 0) checkOutput($sformatf("cont_rvalid_%0d", i), rvalid, prevGnt);
            prevGnt = expGnt;
            nextCycle();
        end

        // Locked four-beat read burst from port 0 while port 1 waits
        for (int b = 0; b < 4; b++) begin
            addr[PORT_INNER] = 17'h00100 + 17'(b);
            applyStimulus(3'b011, (b < 3) ? 3'b001 : 3'b000, 3'b000);
            @(negedge clk);
            checkOutput($sformatf("burst_gnt_%0d", b), gnt, 3'b001);
            checkOutput($sformatf("burst_mem_a_%0d", b), memA, 17'h00100 + 17'(b));
            if (b > 0) begin
                checkOutput($sformatf("burst_rvalid_%0d", b), rvalid, 3'b001);
                checkOutput($sformatf("burst_rdata_%0d", b), rdata, burstData[b-1]);
            end
            nextCycle();
        end
        applyStimulus(3'b010, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("burst_next_gnt", gnt, 3'b010);
        checkOutput("burst_last_rvalid", rvalid, 3'b001);
        checkOutput("burst_last_rdata", rdata, 8'h44);
        nextCycle();

        applyStimulus(3'b000, 3'b000, 3'b000);
        nextCycle();

        // Lock timeout: port 2 holds lock, port 1 joins the next cycle
        addr[PORT_OUTER]  = 17'h00ABC;
        addr[PORT_OUTBUF] = 17'h00ABC;
        applyStimulus(3'b100, 3'b100, 3'b000);
        @(negedge clk);
        checkOutput("tmo_gnt_0", gnt, 3'b100);
        nextCycle();
        for (int c = 1; c < 20; c++) begin
            applyStimulus(3'b110, 3'b100, 3'b000);
            if (c <= 15) expGnt = 3'b100;
            else if (c == 16) expGnt = 3'b010;
            else begin
`ifdef MB8_ARB_RR_EN
                expGnt = 3'b100;
`else
                expGnt = 3'b010;
`endif
            end
            @(negedge clk);
            checkOutput($sformatf("tmo_gnt_%0d", c), gnt, expGnt);
            nextCycle();
        end

        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("norq_gnt", gnt, 0);
        checkOutput("norq_mem_we", memWe, 0);
        checkOutput("norq_mem_a_hold", memA, 17'h00ABC);
        nextCycle();

        // Write from port 1, then read back from port 0 at the top address
        addr[PORT_OUTER]  = 17'h1FFFF;
        wdata[PORT_OUTER] = 8'h5A;
        applyStimulus(3'b010, 3'b000, 3'b010);
        @(negedge clk);
        checkOutput("wr_gnt", gnt, 3'b010);
        checkOutput("wr_mem_we", memWe, 1);
        checkOutput("wr_mem_a", memA, 17'h1FFFF);
        checkOutput("wr_mem_din", memDin, 8'h5A);
        nextCycle();
        addr[PORT_INNER] = 17'h1FFFF;
        applyStimulus(3'b001, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("wrrd_gnt", gnt, 3'b001);
        checkOutput("wr_no_rvalid", rvalid, 0);
        checkOutput("wrrd_mem_we", memWe, 0);
        nextCycle();
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("wrrd_rvalid", rvalid, 3'b001);
        checkOutput("wrrd_rdata", rdata, 8'h5A);
        nextCycle();

        // Reset during beat 2 of a locked burst from port 2
        addr[PORT_OUTBUF] = 17'h00100;
        applyStimulus(3'b100, 3'b100, 3'b000);
        @(negedge clk);
        checkOutput("rstb_gnt_0", gnt, 3'b100);
        nextCycle();
        rst = 1'b1;
        addr[PORT_OUTBUF] = 17'h00101;
        @(negedge clk);
        checkOutput("rstb_gnt_rst", gnt, 0);
        checkOutput("rstb_rvalid_rst", rvalid, 0);
        checkOutput("rstb_mem_we_rst", memWe, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(3'b110, 3'b100, 3'b000);
        @(negedge clk);
        checkOutput("rstb_gnt_post", gnt, 3'b010);
        checkOutput("rstb_rvalid_post", rvalid, 0);
        nextCycle();
        applyStimulus(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        checkOutput("rstb_rvalid_next", rvalid, 3'b010);
        checkOutput("rstb_gnt_idle", gnt, 0);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
